// File: rtl/mul_seq_if.sv
// Execute-stage multiply sequencer bus: request side from EX, result side
// toward the EX->MEM register, plus the stall to the hazard unit.
interface mul_seq_if #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDR_SIZE = 5
);
  logic                 EX_mul;
  logic [XLEN-1:0]      EX_a;
  logic [XLEN-1:0]      EX_b;
  logic [ADDR_SIZE-1:0] EX_rd;
  logic                 kill;
  logic                 stall_mul;
  logic                 MUL_valid;
  logic [XLEN-1:0]      MUL_result;
  logic [ADDR_SIZE-1:0] MUL_rd;

  // Pipeline side: issues requests and flushes, consumes results.
  modport master (
    output EX_mul, EX_a, EX_b, EX_rd, kill,
    input  stall_mul, MUL_valid, MUL_result, MUL_rd
  );

  // Sequencer side.
  modport slave (
    input  EX_mul, EX_a, EX_b, EX_rd, kill,
    output stall_mul, MUL_valid, MUL_result, MUL_rd
  );
endinterface

// File: rtl/mul_seq.sv
// Iterative radix-2 shift-add multiplier for the execute stage. Returns the
// low XLEN bits of EX_a * EX_b (sign-agnostic) and holds the front of the
// pipeline while iterating.
// Optional feature: define MUL_EARLY_OUT_EN to leave BUSY as soon as the
// remaining multiplier bits are all zero (variable latency, same result).
module mul_seq #(
  parameter int unsigned XLEN      = 32,
  parameter int unsigned ADDR_SIZE = 5,
  parameter int unsigned CNT_BITS  = 6
) (
  input  logic     clk,
  input  logic     rst,
  mul_seq_if.slave bus
);

  typedef enum logic [1:0] {StIdle, StBusy, StDone} state_e;

  localparam logic [CNT_BITS-1:0] LastCnt = CNT_BITS'(XLEN - 1);

  state_e               state_q, state_d;
  logic [XLEN-1:0]      acc_q, acc_d;
  logic [XLEN-1:0]      mcand_q, mcand_d;
  logic [XLEN-1:0]      mplier_q, mplier_d;
  logic [CNT_BITS-1:0]  cnt_q, cnt_d;
  logic [ADDR_SIZE-1:0] rd_q, rd_d;
  logic                 stall_mul;
  logic                 mul_valid;

  // Next-state, datapath iteration and handshake outputs.
  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    mcand_d   = mcand_q;
    mplier_d  = mplier_q;
    cnt_d     = cnt_q;
    rd_d      = rd_q;
    stall_mul = 1'b0;
    mul_valid = 1'b0;
    unique case (state_q)
      StIdle: begin
        // Stall combinationally so the requester is held from its first cycle.
        if (bus.EX_mul && !bus.kill) begin
          state_d   = StBusy;
          acc_d     = '0;
          mcand_d   = bus.EX_a;
          mplier_d  = bus.EX_b;
          rd_d      = bus.EX_rd;
          cnt_d     = '0;
          stall_mul = 1'b1;
        end
      end
      StBusy: begin
        stall_mul = 1'b1;
        if (bus.kill) begin
          state_d = StIdle;
        end else begin
          if (mplier_q[0]) begin
            acc_d = acc_q + mcand_q;
          end
          mcand_d  = mcand_q << 1;
          mplier_d = mplier_q >> 1;
          cnt_d    = cnt_q + 1'b1;
          if (cnt_q == LastCnt) begin
            state_d = StDone;
          end
`ifdef MUL_EARLY_OUT_EN
          if (mplier_d == '0) begin
            state_d = StDone;
          end
`endif
        end
      end
      StDone: begin
        // Stall drops here so the instruction leaves on the same edge as the result.
        mul_valid = !bus.kill;
        state_d   = StIdle;
      end
      default: begin
        state_d = StIdle;
      end
    endcase
  end

  // State and datapath registers with synchronous reset.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= StIdle;
      acc_q    <= '0;
      mcand_q  <= '0;
      mplier_q <= '0;
      cnt_q    <= '0;
      rd_q     <= '0;
    end else begin
      state_q  <= state_d;
      acc_q    <= acc_d;
      mcand_q  <= mcand_d;
      mplier_q <= mplier_d;
      cnt_q    <= cnt_d;
      rd_q     <= rd_d;
    end
  end

  assign bus.stall_mul  = stall_mul;
  assign bus.MUL_valid  = mul_valid;
  assign bus.MUL_result = acc_q;
  assign bus.MUL_rd     = rd_q;

endmodule

// File: tb/tb_mul_seq.sv
// Directed bench for mul_seq: latency, stall window, wrap-around, zero
// multiplier, kill in BUSY/IDLE/DONE, and reset mid-operation.
module tb_mul_seq;

  logic clk;
  logic rst;
  int   errors;
  int   checks;

  mul_seq_if #(.XLEN(32), .ADDR_SIZE(5)) bus ();

  mul_seq #(.XLEN(32), .ADDR_SIZE(5), .CNT_BITS(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Hand-computed total latencies (request cycle to valid cycle).
`ifdef MUL_EARLY_OUT_EN
  localparam int LatB6   = 4;   // 6 = 110b
  localparam int LatB2   = 3;   // 2 = 10b
  localparam int LatBMsb = 33;  // bit 31 set
  localparam int LatB0   = 2;
  localparam int LatB4   = 4;   // 4 = 100b
  localparam int LatB3   = 3;   // 3 = 11b
  localparam int LatB9   = 5;   // 9 = 1001b
  localparam int KillAt  = 2;   // still inside BUSY for 5 = 101b
`else
  localparam int LatB6   = 33;
  localparam int LatB2   = 33;
  localparam int LatBMsb = 33;
  localparam int LatB0   = 33;
  localparam int LatB4   = 33;
  localparam int LatB3   = 33;
  localparam int LatB9   = 33;
  localparam int KillAt  = 10;
`endif

  // Advance to just after the next rising edge (start of a new cycle).
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    tick();
    tick();
    #3;
    checks++;
    if (bus.stall_mul !== 1'b0) $display("FAIL reset_stall got=%b want=0", bus.stall_mul);
    if (bus.stall_mul !== 1'b0) errors++;
    checks++;
    if (bus.MUL_valid !== 1'b0) begin
      errors++;
      $display("FAIL reset_valid got=%b want=0", bus.MUL_valid);
    end
    checks++;
    if (bus.MUL_result !== 32'd0) begin
      errors++;
      $display("FAIL reset_result got=%h want=0", bus.MUL_result);
    end
    checks++;
    if (bus.MUL_rd !== 5'd0) begin
      errors++;
      $display("FAIL reset_rd got=%0d want=0", bus.MUL_rd);
    end
    rst = 1'b0;
    tick();
  endtask

  // One multiply starting this cycle; checks stall window, single valid
  // pulse and result/rd. Returns at the cycle after DONE.
  task automatic test_mul(input logic [31:0] a, input logic [31:0] b, input logic [4:0] rd,
                          input logic [31:0] exp, input int lat, input string name);
    logic exp_stall;
    logic exp_valid;
    bus.EX_a   = a;
    bus.EX_b   = b;
    bus.EX_rd  = rd;
    bus.EX_mul = 1'b1;
    for (int c = 0; c <= lat; c++) begin
      // Operands must have been sampled only at capture.
      if (c == 1) begin
        bus.EX_a  = 32'hDEAD_BEEF;
        bus.EX_b  = 32'h0F0F_0F0F;
        bus.EX_rd = 5'd31;
      end
      if (c == lat) bus.EX_mul = 1'b0;
      #3;
      exp_stall = (c < lat);
      exp_valid = (c == lat);
      checks++;
      if (bus.stall_mul !== exp_stall) begin
        errors++;
        $display("FAIL %s_stall c=%0d got=%b want=%b", name, c, bus.stall_mul, exp_stall);
      end
      checks++;
      if (bus.MUL_valid !== exp_valid) begin
        errors++;
        $display("FAIL %s_valid c=%0d got=%b want=%b", name, c, bus.MUL_valid, exp_valid);
      end
      if (c == lat) begin
        checks++;
        if (bus.MUL_result !== exp) begin
          errors++;
          $display("FAIL %s_result got=%h want=%h", name, bus.MUL_result, exp);
        end
        checks++;
        if (bus.MUL_rd !== rd) begin
          errors++;
          $display("FAIL %s_rd got=%0d want=%0d", name, bus.MUL_rd, rd);
        end
      end
      tick();
    end
  endtask

  task automatic test_back_to_back();
    test_mul(32'hFFFF_FFFF, 32'd2, 5'd5, 32'hFFFF_FFFE, LatB2, "b2b_ffff_x2");
    test_mul(32'h8000_0000, 32'h8000_0000, 5'd7, 32'd0, LatBMsb, "b2b_wrap");
  endtask

  task automatic test_kill_busy();
    bus.EX_a   = 32'd5;
    bus.EX_b   = 32'd5;
    bus.EX_rd  = 5'd4;
    bus.EX_mul = 1'b1;
    for (int c = 0; c <= KillAt; c++) begin
      if (c == KillAt) bus.kill = 1'b1;
      #3;
      checks++;
      if (bus.stall_mul !== 1'b1) begin
        errors++;
        $display("FAIL kill_busy_stall c=%0d got=%b want=1", c, bus.stall_mul);
      end
      tick();
    end
    bus.kill   = 1'b0;
    bus.EX_mul = 1'b0;
    #3;
    checks++;
    if (bus.stall_mul !== 1'b0) begin
      errors++;
      $display("FAIL kill_busy_idle_stall got=%b want=0", bus.stall_mul);
    end
    checks++;
    if (bus.MUL_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_busy_valid got=%b want=0", bus.MUL_valid);
    end
    tick();
    test_mul(32'd3, 32'd4, 5'd9, 32'd12, LatB4, "after_kill");
  endtask

  task automatic test_kill_idle_done();
    int vcount;
    // Request and kill together in IDLE: nothing captured.
    bus.EX_a   = 32'd11;
    bus.EX_b   = 32'd11;
    bus.EX_rd  = 5'd17;
    bus.EX_mul = 1'b1;
    bus.kill   = 1'b1;
    #3;
    checks++;
    if (bus.stall_mul !== 1'b0) begin
      errors++;
      $display("FAIL kill_idle_stall got=%b want=0", bus.stall_mul);
    end
    tick();
    bus.EX_mul = 1'b0;
    bus.kill   = 1'b0;
    vcount = 0;
    for (int c = 0; c < 40; c++) begin
      #3;
      if (bus.MUL_valid === 1'b1 || bus.stall_mul === 1'b1) vcount++;
      tick();
    end
    checks++;
    if (vcount !== 0) begin
      errors++;
      $display("FAIL kill_idle_activity got=%0d cycles want=0", vcount);
    end
    checks++;
    if (bus.MUL_rd !== 5'd9) begin
      errors++;
      $display("FAIL kill_idle_rd got=%0d want=9", bus.MUL_rd);
    end
    // Kill during DONE suppresses valid.
    bus.EX_a   = 32'd2;
    bus.EX_b   = 32'd3;
    bus.EX_rd  = 5'd6;
    bus.EX_mul = 1'b1;
    for (int c = 0; c < LatB3; c++) tick();
    bus.EX_mul = 1'b0;
    bus.kill   = 1'b1;
    #3;
    checks++;
    if (bus.MUL_valid !== 1'b0) begin
      errors++;
      $display("FAIL kill_done_valid got=%b want=0", bus.MUL_valid);
    end
    checks++;
    if (bus.stall_mul !== 1'b0) begin
      errors++;
      $display("FAIL kill_done_stall got=%b want=0", bus.stall_mul);
    end
    checks++;
    if (bus.MUL_result !== 32'd6) begin
      errors++;
      $display("FAIL kill_done_result got=%h want=6", bus.MUL_result);
    end
    tick();
    bus.kill = 1'b0;
    #3;
    checks++;
    if (bus.MUL_valid !== 1'b0 || bus.stall_mul !== 1'b0) begin
      errors++;
      $display("FAIL kill_done_after got=%b%b want=00", bus.MUL_valid, bus.stall_mul);
    end
    tick();
  endtask

  task automatic test_rst_mid();
    bus.EX_a   = 32'd3;
    bus.EX_b   = 32'h8000_0001;
    bus.EX_rd  = 5'd12;
    bus.EX_mul = 1'b1;
    for (int c = 0; c <= 20; c++) begin
      #3;
      checks++;
      if (bus.stall_mul !== 1'b1) begin
        errors++;
        $display("FAIL rst_mid_stall c=%0d got=%b want=1", c, bus.stall_mul);
      end
      if (c == 20) begin
        rst        = 1'b1;
        bus.EX_mul = 1'b0;
      end
      tick();
    end
    rst = 1'b0;
    #3;
    checks++;
    if (bus.stall_mul !== 1'b0 || bus.MUL_valid !== 1'b0) begin
      errors++;
      $display("FAIL rst_mid_ctrl got=%b%b want=00", bus.stall_mul, bus.MUL_valid);
    end
    checks++;
    if (bus.MUL_result !== 32'd0) begin
      errors++;
      $display("FAIL rst_mid_result got=%h want=0", bus.MUL_result);
    end
    checks++;
    if (bus.MUL_rd !== 5'd0) begin
      errors++;
      $display("FAIL rst_mid_rd got=%0d want=0", bus.MUL_rd);
    end
    tick();
    test_mul(32'd9, 32'd9, 5'd13, 32'd81, LatB9, "after_rst");
  endtask

  initial begin
    errors     = 0;
    checks     = 0;
    rst        = 1'b1;
    bus.EX_mul = 1'b0;
    bus.EX_a   = '0;
    bus.EX_b   = '0;
    bus.EX_rd  = '0;
    bus.kill   = 1'b0;
    tick();
    test_reset();
    test_mul(32'd7, 32'd6, 5'd3, 32'd42, LatB6, "basic_7x6");
    test_back_to_back();
    test_mul(32'h1234, 32'd0, 5'd8, 32'd0, LatB0, "zero_b");
    test_kill_busy();
    test_kill_idle_done();
    test_rst_mid();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog timeout errors=%0d checks=%0d", errors, checks);
    $fatal(1, "timeout");
  end

endmodule
